param_seq_detector: RTL and testbench
=====================================

Name: param_seq_detector

Overview:
Parametrised Mealy digit-sequence detector. It is the successor of the fixed eight-digit detector. Digit width, maximum pattern length, the pattern itself and overlap mode are all configurable. The block sits between a digit source (keypad or serial decoder) and control logic, which consumes the detection strobe and the match count.

Parameters:
N, 4, digit width in bits
LEN, 8, maximum pattern length in digits (2..16)
DEF_PATTERN, {4'd8,4'd2,4'd4,4'd4,4'd4,4'd3,4'd0,4'd0}, reset pattern (LEN*N bits); digit 0 is the first expected and sits at the MSB end
DEF_LEN, 8, reset/default active length
CNT_W, 8, match counter width

Ports:
clk  input  1  rising-edge clock
syn_rst  input  1  synchronous reset, active-high
start  input  1  arm detector, latch cfg_len/cfg_overlap
stop  input  1  return to IDLE
digit_valid  input  1  digit_in qualifier
digit_in  input  N  incoming digit
cfg_len  input  $clog2(LEN+1)  active pattern length, sampled on start
cfg_overlap  input  1  1 = overlapping matches, sampled on start
wr_en  input  1  pattern digit write strobe
wr_idx  input  $clog2(LEN)  pattern position to write
wr_digit  input  N  pattern digit value
clear_count  input  1  zero match_count
sequence_detected  output  1  Mealy match strobe, combinational
match_count  output  CNT_W  saturating count of matches
busy  output  1  state != IDLE (registered)
cfg_err  output  1  one-cycle registered pulse on a rejected write

Behaviour:
- Reset (syn_rst=1 at clk edge):
  - state=IDLE; pattern regs=DEF_PATTERN; len_q=DEF_LEN; overlap_q=0.
  - fill=0; history cleared; match_count=0; busy=0; cfg_err=0.
  - Reset mid-operation aborts immediately; no detection in that cycle.
- States: IDLE, FILL (fill < len_q-1), HUNT (fill >= len_q-1).
- IDLE:
  - digits ignored; sequence_detected=0.
  - wr_en writes pattern[wr_idx]=wr_digit.
  - wr_idx >= LEN: write ignored, cfg_err pulses.
  - start -> FILL with fill=0; len_q=cfg_len; overlap_q=cfg_overlap.
  - cfg_len of 0 or > LEN is clamped to LEN.
- FILL/HUNT:
  - wr_en is ignored and cfg_err pulses the next cycle.
  - On digit_valid, the digit shifts into history (h[0] = most recent) and fill increments, saturating at LEN-1.
  - FILL -> HUNT when fill reaches len_q-1.
- Match condition (Mealy, same cycle as the final digit; no latency):
  - Requires state==HUNT, digit_valid=1 and digit_in == pattern[len_q-1].
  - Also requires h[k-1] == pattern[len_q-1-k] for k = 1..len_q-1.
  - Only the first len_q pattern positions are used.
  - len_q=1: match needs only the digit compare; the block enters HUNT directly from start.
- On match:
  - sequence_detected=1 (combinational).
  - match_count increments next edge, saturating at all-ones.
  - overlap_q=1: history and fill retained; the next match may share digits.
  - overlap_q=0: fill cleared to 0 and state -> FILL (or stays HUNT if len_q=1).
- Mismatch: no reset of history; the shift-register compare finds the next alignment naturally. This corrects the fixed block's restart-to-S1 behaviour, which lost prefixes.
- digit_valid=0: no shift, no detection, state held.
- stop in any state -> IDLE, fill=0; match_count retained.
- Simultaneous events:
  - stop and start: stop wins.
  - start while busy: re-arm with fill=0 and new config; the digit in that cycle is neither detected nor stored.
  - clear_count and match: count=0 (clear wins).
  - start and wr_en in IDLE: write accepted and start taken; the new digit is used for the following digits.
- sequence_detected is 0 in IDLE, during reset, and in any cycle containing stop or start.

Test Plan:
- Defaults after reset, start=1, cfg_len=8, cfg_overlap=0, digits 8,2,4,4,4,3,0,0 -> sequence_detected high only on the final 0 digit; match_count=1.
- Prefix recovery: digits 8,8,2,4,4,4,3,0,0 -> exactly one detection, on the final 0 (the fixed design misses this case).
- Overlap: write pattern 1,2,1 in IDLE, cfg_len=3. With cfg_overlap=1, digits 1,2,1,2,1 -> detections on 3rd and 5th digits, count=2. With cfg_overlap=0, same stream -> only on the 3rd digit, count=1.
- Gaps and abort: pattern 8,2,4 with digit_valid low for 3 cycles between digits -> detection still occurs. stop after 8,2 then restart and send 4 -> no detection.
- Config rules: wr_en while busy -> pattern unchanged, cfg_err one-cycle pulse. wr_idx=LEN in IDLE -> cfg_err. cfg_len=0 -> len_q=8 behaviour.
- Counter rules: CNT_W=2 with 5 matches -> match_count saturates at 3. clear_count coincident with a match -> 0. syn_rst mid-FILL -> all outputs 0, pattern back to DEF_PATTERN.

Source files
------------

// File: rtl/param_seq_detector.sv
// -----------------------------------------------------------------------------
// param_seq_detector
//   Parametrised Mealy digit-sequence detector. Incoming digits shift into a
//   history register (h[0] = most recent) and every qualified digit is compared
//   against the active part of a writable pattern. The detection strobe is
//   combinational, so it rises in the same cycle as the final digit of a match.
//
// Ports
//   clk               rising-edge clock
//   syn_rst           synchronous reset, active-high
//   start             arm the detector, latch cfg_len / cfg_overlap
//   stop              return to IDLE (wins over start)
//   digit_valid       qualifies digit_in
//   digit_in          incoming digit
//   cfg_len           active pattern length (0 or > LEN clamps to LEN)
//   cfg_overlap       1 = matches may share digits
//   wr_en/wr_idx/wr_digit  pattern write port, honoured only in IDLE
//   clear_count       zero match_count (wins over a coincident match)
//   sequence_detected Mealy match strobe
//   match_count       saturating match counter
//   busy              detector armed (state != IDLE)
//   cfg_err           one-cycle pulse after a rejected pattern write
// -----------------------------------------------------------------------------
module param_seq_detector #(
  parameter int N = 4,
  parameter int LEN = 8,
  parameter logic [LEN*N-1:0] DEF_PATTERN = {4'd8, 4'd2, 4'd4, 4'd4, 4'd4, 4'd3, 4'd0, 4'd0},
  parameter int DEF_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(LEN + 1),
  localparam int IW = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             syn_rst,
  input  logic             start,
  input  logic             stop,
  input  logic             digit_valid,
  input  logic [N-1:0]     digit_in,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [N-1:0]     wr_digit,
  input  logic             clear_count,
  output logic             sequence_detected,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_HUNT} state_t;

  localparam logic [LW-1:0] LEN_L    = LW'(LEN);
  localparam logic [IW-1:0] FILL_MAX = IW'(LEN - 1);
  localparam logic [IW:0]   LEN_I    = (IW + 1)'(LEN);

  state_t             r_state;
  state_t             w_state_next;
  logic [IW-1:0]      r_fill;
  logic [IW-1:0]      w_fill_next;
  logic [IW-1:0]      w_fill_inc;
  logic [LW-1:0]      r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_count;
  logic               r_busy;
  logic               r_cfg_err;
  logic [N-1:0]       r_pattern [LEN];
  logic [N-1:0]       r_hist    [LEN-1];

  logic [LW-1:0]      w_len_clamped;
  logic [IW-1:0]      w_len_m1;
  logic [LEN-1:0]     w_pos_cmp;
  logic               w_match;
  logic               w_shift;
  logic               w_idx_ok;
  logic               w_wr_ok;

  assign w_len_clamped = ((cfg_len == '0) || (cfg_len > LEN_L)) ? LEN_L : cfg_len;
  assign w_len_m1      = IW'(r_len - 1'b1);
  assign w_fill_inc    = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
  assign w_idx_ok      = ({1'b0, wr_idx} < LEN_I);
  assign w_wr_ok       = wr_en && (r_state == S_IDLE) && w_idx_ok;

  // Position 0 is the digit arriving now against the last active pattern
  // digit; position k checks h[k-1] against pattern[len_q-1-k]. Positions at
  // or beyond the active length are forced true.
  assign w_pos_cmp[0] = (digit_in == r_pattern[w_len_m1]);
  for (genvar gi = 1; gi < LEN; gi++) begin : g_cmp
    assign w_pos_cmp[gi] = (gi >= int'(r_len)) ||
                           (r_hist[gi-1] == r_pattern[IW'(int'(r_len) - 1 - gi)]);
  end

  // Any cycle carrying stop, start or reset never reports a match.
  assign w_match = (r_state == S_HUNT) && digit_valid && !stop && !start &&
                   !syn_rst && (&w_pos_cmp);

  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill;
    w_shift      = 1'b0;
    if (stop) begin
      w_state_next = S_IDLE;
      w_fill_next  = '0;
    end else if (start) begin
      // Re-arming discards the digit of this cycle.
      w_fill_next  = '0;
      w_state_next = (w_len_clamped == LW'(1)) ? S_HUNT : S_FILL;
    end else if ((r_state != S_IDLE) && digit_valid) begin
      w_shift = 1'b1;
      if (w_match && !r_overlap) begin
        w_fill_next  = '0;
        w_state_next = (r_len == LW'(1)) ? S_HUNT : S_FILL;
      end else begin
        w_fill_next  = w_fill_inc;
        w_state_next = (w_fill_inc >= w_len_m1) ? S_HUNT : S_FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      r_state   <= S_IDLE;
      r_fill    <= '0;
      r_len     <= LW'(DEF_LEN);
      r_overlap <= 1'b0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_fill    <= w_fill_next;
      r_busy    <= (w_state_next != S_IDLE);
      r_cfg_err <= wr_en && ((r_state != S_IDLE) || !w_idx_ok);
      if (start && !stop) begin
        r_len     <= w_len_clamped;
        r_overlap <= cfg_overlap;
      end
      if (clear_count) begin
        r_count <= '0;
      end else if (w_match && (r_count != '1)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Pattern store: digit 0 of DEF_PATTERN sits at the MSB end.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      for (int i = 0; i < LEN; i++) begin
        r_pattern[i] <= DEF_PATTERN[(LEN-1-i)*N +: N];
      end
    end else if (w_wr_ok) begin
      r_pattern[wr_idx] <= wr_digit;
    end
  end

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      for (int i = 0; i < LEN-1; i++) begin
        r_hist[i] <= '0;
      end
    end else if (w_shift) begin
      r_hist[0] <= digit_in;
      for (int i = 1; i < LEN-1; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end
  end

  assign sequence_detected = w_match;
  assign match_count       = r_count;
  assign busy              = r_busy;
  assign cfg_err           = r_cfg_err;

endmodule

// File: tb/tb_param_seq_detector.sv
module tb_param_seq_detector;

  logic       clk = 1'b0;
  logic       syn_rst, start, stop, digit_valid, cfg_overlap;
  logic       wr_en, clear_count;
  logic [3:0] digit_in, wr_digit, cfg_len;
  logic [2:0] cfg_len5, wr_idx;

  logic       det, busy, cfg_err;
  logic [7:0] cnt;
  logic       det5, busy5, cfg_err5;
  logic [1:0] cnt5;

  int vectors = 0;
  int miscompares = 0;
  int which = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  param_seq_detector dut (
    .clk(clk), .syn_rst(syn_rst), .start(start), .stop(stop),
    .digit_valid(digit_valid), .digit_in(digit_in), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_digit(wr_digit), .clear_count(clear_count),
    .sequence_detected(det), .match_count(cnt), .busy(busy), .cfg_err(cfg_err)
  );

  param_seq_detector #(
    .N(4), .LEN(5), .DEF_PATTERN({4'd1, 4'd2, 4'd3, 4'd4, 4'd5}),
    .DEF_LEN(5), .CNT_W(2)
  ) dut5 (
    .clk(clk), .syn_rst(syn_rst), .start(start), .stop(stop),
    .digit_valid(digit_valid), .digit_in(digit_in), .cfg_len(cfg_len5),
    .cfg_overlap(cfg_overlap), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_digit(wr_digit), .clear_count(clear_count),
    .sequence_detected(det5), .match_count(cnt5), .busy(busy5), .cfg_err(cfg_err5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
    $display("vector %0d %s observed=%0d expected=%0d", vectors, tag, obs, expv);
  endtask

  // One clock cycle: drive, queue expected strobe, compare strobe mid-cycle,
  // then leave the bench 1 ns after the edge with pulses released.
  task automatic cyc(input logic dv, input logic [3:0] d, input logic e);
    logic got;
    digit_valid = dv;
    digit_in    = d;
    exp_q.push_back(e);
    @(negedge clk);
    got = (which == 0) ? det : det5;
    chk("sequence_detected", {31'd0, got}, {31'd0, exp_q.pop_front()});
    @(posedge clk);
    #1;
    digit_valid = 1'b0; start = 1'b0; stop = 1'b0;
    wr_en = 1'b0; clear_count = 1'b0;
  endtask

  task automatic feed(input logic [3:0] d, input logic e);
    cyc(1'b1, d, e);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [3:0] dig);
    wr_en = 1'b1; wr_idx = idx; wr_digit = dig;
    cyc(1'b0, 4'd0, 1'b0);
  endtask

  task automatic arm(input logic [3:0] len, input logic ovl, input logic clr);
    start = 1'b1; cfg_len = len; cfg_overlap = ovl; clear_count = clr;
    cyc(1'b0, 4'd0, 1'b0);
  endtask

  task automatic halt();
    stop = 1'b1;
    cyc(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    syn_rst = 1'b1; start = 1'b0; stop = 1'b0; digit_valid = 1'b0;
    digit_in = '0; cfg_len = 4'd8; cfg_len5 = 3'd5; cfg_overlap = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_digit = '0; clear_count = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_count", {24'd0, cnt}, 0);
    chk("reset_cfg_err", {31'd0, cfg_err}, 0);
    syn_rst = 1'b0;

    // Default pattern, length 8, no overlap
    arm(4'd8, 1'b0, 1'b0);
    chk("busy_after_start", {31'd0, busy}, 1);
    feed(8, 0); feed(2, 0); feed(4, 0); feed(4, 0);
    feed(4, 0); feed(3, 0); feed(0, 0); feed(0, 1);
    chk("count_default", {24'd0, cnt}, 1);

    // Prefix recovery after re-arm while busy
    arm(4'd8, 1'b0, 1'b0);
    feed(8, 0); feed(8, 0); feed(2, 0); feed(4, 0); feed(4, 0);
    feed(4, 0); feed(3, 0); feed(0, 0); feed(0, 1);
    chk("count_prefix", {24'd0, cnt}, 2);

    // Overlap on pattern 1,2,1
    halt();
    chk("busy_after_stop", {31'd0, busy}, 0);
    chk("count_kept_on_stop", {24'd0, cnt}, 2);
    wr(0, 1); wr(1, 2); wr(2, 1);
    chk("cfg_err_idle_write", {31'd0, cfg_err}, 0);
    arm(4'd3, 1'b1, 1'b1);
    feed(1, 0); feed(2, 0); feed(1, 1); feed(2, 0); feed(1, 1);
    chk("count_overlap", {24'd0, cnt}, 2);
    arm(4'd3, 1'b0, 1'b1);
    feed(1, 0); feed(2, 0); feed(1, 1); feed(2, 0); feed(1, 0);
    chk("count_no_overlap", {24'd0, cnt}, 1);

    // Gaps, then abort by stop
    halt();
    wr(0, 8); wr(1, 2); wr(2, 4);
    arm(4'd3, 1'b0, 1'b1);
    feed(8, 0); cyc(0, 2, 0); cyc(0, 2, 0); cyc(0, 2, 0);
    feed(2, 0); cyc(0, 4, 0); cyc(0, 4, 0); cyc(0, 4, 0);
    feed(4, 1);
    chk("count_gaps", {24'd0, cnt}, 1);
    feed(8, 0); feed(2, 0); halt();
    arm(4'd3, 1'b0, 1'b0);
    feed(4, 0);
    chk("count_after_abort", {24'd0, cnt}, 1);

    // Write while busy is rejected
    wr_en = 1'b1; wr_idx = 3'd0; wr_digit = 4'd9;
    cyc(1'b0, 4'd0, 1'b0);
    chk("cfg_err_busy_pulse", {31'd0, cfg_err}, 1);
    cyc(1'b0, 4'd0, 1'b0);
    chk("cfg_err_busy_clear", {31'd0, cfg_err}, 0);
    arm(4'd3, 1'b0, 1'b0);
    feed(8, 0); feed(2, 0); feed(4, 1);
    chk("count_pattern_kept", {24'd0, cnt}, 2);

    // cfg_len 0 clamps to 8; clear_count wins over the final match
    arm(4'd0, 1'b0, 1'b0);
    feed(8, 0); feed(2, 0); feed(4, 0); feed(4, 0);
    feed(4, 0); feed(3, 0); feed(0, 0);
    clear_count = 1'b1;
    feed(0, 1);
    chk("count_clear_wins", {24'd0, cnt}, 0);

    // Length 1, then reset mid-FILL restores the default pattern
    halt();
    wr(0, 5);
    arm(4'd1, 1'b1, 1'b0);
    chk("busy_len1", {31'd0, busy}, 1);
    feed(5, 1); feed(5, 1); feed(4, 0);
    chk("count_len1", {24'd0, cnt}, 2);
    arm(4'd3, 1'b0, 1'b0);
    feed(8, 0);
    syn_rst = 1'b1;
    feed(2, 0);
    syn_rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_count", {24'd0, cnt}, 0);
    chk("rst_mid_cfg_err", {31'd0, cfg_err}, 0);
    arm(4'd1, 1'b0, 1'b0);
    feed(5, 0); feed(8, 1);

    // LEN=5, CNT_W=2 instance: out-of-range write and saturation
    syn_rst = 1'b1;
    cyc(1'b0, 4'd0, 1'b0);
    syn_rst = 1'b0;
    which = 1;
    wr(3'd5, 4'd7);
    chk("cfg_err_bad_idx", {31'd0, cfg_err5}, 1);
    cyc(1'b0, 4'd0, 1'b0);
    chk("cfg_err_bad_idx_clear", {31'd0, cfg_err5}, 0);
    cfg_len5 = 3'd1;
    arm(4'd1, 1'b1, 1'b0);
    feed(1, 1); feed(1, 1); feed(1, 1);
    chk("count5_three", {30'd0, cnt5}, 3);
    feed(1, 1); feed(1, 1);
    chk("count5_saturated", {30'd0, cnt5}, 3);
    feed(2, 0);
    chk("busy5", {31'd0, busy5}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
